// File: rtl/ex_div_if.sv
// Execute-stage <-> divide-unit bundle: request, operands, mode bits, flush, stall and result.
interface ex_div_if #(parameter int XLEN = 32);
  logic            start_i;
  logic            signed_i;
  logic            rem_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            annul_i;
  logic            stallreq_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, signed_i, rem_i, dividend_i, divisor_i, annul_i,
    input  stallreq_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, rem_i, dividend_i, divisor_i, annul_i,
    output stallreq_o, ready_o, result_o
  );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring RV32M divider (DIV/DIVU/REM/REMU): result XLEN+1 cycles after accept, 1 for divide-by-zero.
// Backpressure is a stall request held from accept through the last step; annul cancels at any point.
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] prem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   cnt;
  logic            rem_sel, q_sign, r_sign;

  logic            accept, div_zero, last, stall, ready;
  logic [XLEN-1:0] dvd_abs, dvs_abs, fixed;
  logic [XLEN:0]   shifted, diff;

  assign accept   = (state == IDLE) & bus.start_i & ~bus.annul_i;
  assign div_zero = (bus.divisor_i == '0);
  assign dvd_abs  = (bus.signed_i & bus.dividend_i[XLEN-1]) ? -bus.dividend_i : bus.dividend_i;
  assign dvs_abs  = (bus.signed_i & bus.divisor_i[XLEN-1])  ? -bus.divisor_i  : bus.divisor_i;
  assign last     = (cnt == CW'(XLEN - 1));

  // Restored remainder is always below the divisor, so XLEN bits of storage suffice between steps.
  assign shifted  = {prem, quo[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs};

  assign fixed = rem_sel ? (r_sign ? -prem : prem)
                         : (q_sign ? -quo  : quo);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = div_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.annul_i) begin
      state_nxt = IDLE;
      stall     = 1'b0;
      ready     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prem     <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      rem_sel  <= 1'b0;
      q_sign   <= 1'b0;
      r_sign   <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        rem_sel <= bus.rem_i;
        dvs     <= dvs_abs;
        cnt     <= '0;
        if (div_zero) begin
          // Architected divide-by-zero results bypass the sign fixup entirely.
          quo    <= '1;
          prem   <= bus.dividend_i;
          q_sign <= 1'b0;
          r_sign <= 1'b0;
        end else begin
          quo    <= dvd_abs;
          prem   <= '0;
          q_sign <= bus.signed_i & (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
          r_sign <= bus.signed_i & bus.dividend_i[XLEN-1];
        end
      end else if (state == BUSY && !bus.annul_i) begin
        cnt <= cnt + 1'b1;
        if (!diff[XLEN]) begin
          prem <= diff[XLEN-1:0];
          quo  <= {quo[XLEN-2:0], 1'b1};
        end else begin
          prem <= shifted[XLEN-1:0];
          quo  <= {quo[XLEN-2:0], 1'b0};
        end
      end
      if (ready) result_q <= fixed;
    end
  end

  assign bus.stallreq_o = stall;
  assign bus.ready_o    = ready;
  assign bus.result_o   = ready ? fixed : result_q;
endmodule

// File: doc/ex_div.md
# ex_div

Iterative RV32M divide unit with its own sequencing FSM. It executes DIV, DIVU, REM and REMU for the execute stage and holds the pipeline with a stall request until the result is ready. The execute stage decodes the instruction and drives `start_i`, the operands and the mode bits. It muxes `result_o` into its write-back data on the `ready_o` cycle. One divide is in flight at a time. Pipeline flushes cancel it through `annul_i`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-low (`rst`=0 resets on the next rising edge of `clk`)
- `start_i`  in  1  divide request from execute stage; held high while the stage is stalled
- `signed_i`  in  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU
- `rem_i`  in  1  1 = return remainder, 0 = return quotient
- `dividend_i`  in  XLEN  rs1 value
- `divisor_i`  in  XLEN  rs2 value
- `annul_i`  in  1  flush; cancels any request or operation in flight
- `stallreq_o`  out  1  stall request to pipeline control
- `ready_o`  out  1  one-cycle pulse; `result_o` valid
- `result_o`  out  XLEN  quotient or remainder, held until next accepted start

## Operation
- States: IDLE, BUSY, DONE. Reset forces IDLE.
- Reset values: `ready_o`=0, `result_o`=0, iteration counter=0, internal operand/sign registers=0.
- IDLE, accept condition `start_i`=1 and `annul_i`=0:
  - Latch `rem_i`.
  - Latch the quotient sign = `signed_i` & (dividend[XLEN-1] ^ divisor[XLEN-1]).
  - Latch the remainder sign = `signed_i` & dividend[XLEN-1].
  - Latch operand magnitudes: absolute values when `signed_i`=1, raw values otherwise.
- Divisor zero at accept: go directly to DONE.
  - Quotient = all ones (0xFFFFFFFF).
  - Remainder = `dividend_i` unmodified.
  - No sign fixup in this case.
- Divisor nonzero at accept: clear the partial remainder, load the magnitudes, counter=0, go to BUSY.
- BUSY, one restoring step per cycle on the (XLEN+1)-bit partial remainder:
  - Shift {partial remainder, quotient} left by 1, taking in the dividend MSB.
  - Trial-subtract the divisor.
  - On non-negative result, keep the difference and set quotient LSB=1; otherwise restore and set LSB=0.
  - Counter increments each step. After step XLEN-1, go to DONE.
- DONE: apply fixups, then go to IDLE unconditionally.
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the remainder sign is set.
  - `result_o` gets the selected value; `ready_o`=1 for exactly this cycle.
  - `start_i` still high in DONE (the same instruction) is ignored.
- Signed overflow (0x80000000 / 0xFFFFFFFF) needs no special path. Magnitude 2^31 divided by 1 yields quotient 0x80000000 and remainder 0.
- `stallreq_o` is combinational: (IDLE & `start_i` & ~`annul_i`) | BUSY. It is low in DONE so the pipeline advances on the `ready_o` cycle.
- `annul_i`=1 in any state:
  - Next state is IDLE and `ready_o` stays 0 (this has priority over DONE).
  - `stallreq_o` is forced low the same cycle.
  - `result_o` keeps its previous value.

## Timing
- Accept edge is cycle 0 (IDLE, `stallreq_o`=1 combinationally).
- Nonzero divisor: BUSY cycles 1..XLEN, DONE at cycle XLEN+1 (33 for XLEN=32), `ready_o` pulse at cycle 33, `stallreq_o` high cycles 0..32.
- Zero divisor: DONE at cycle 1 with `ready_o`=1; `stallreq_o` high cycle 0 only.
- A new request is accepted at the earliest in the cycle after DONE (back-to-back throughput = XLEN+2 cycles).
- Reset mid-operation: the next edge with `rst`=0 returns to IDLE with all reset values; no `ready_o` pulse.
- Operands are sampled only at accept; changes on `dividend_i`/`divisor_i` during BUSY have no effect.

## Test plan
- DIVU 100/7: `ready_o` at cycle 33, `result_o`=14. REMU 100/7 gives 2. `stallreq_o` high cycles 0..32, low at 33.
- DIV −7/2 (0xFFFFFFF9 / 2) gives 0xFFFFFFFD. REM gives 0xFFFFFFFF. DIV 7/−2 gives 0xFFFFFFFD. REM 7/−2 gives 1.
- Divide by zero:
  - DIVU 5/0 gives 0xFFFFFFFF at cycle 1.
  - REMU 5/0 gives 5.
  - DIV −5/0 gives 0xFFFFFFFF.
  - REM −5/0 gives 0xFFFFFFFB.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0. Each completes at cycle 33.
- Annul: assert `annul_i` at cycle 10 of a DIVU.
  - `stallreq_o`=0 at cycle 10 and IDLE at cycle 11.
  - No `ready_o` pulse; `result_o` unchanged.
  - A fresh DIVU 9/3 started at cycle 12 gives 3 at cycle 45.
- Reset: drive `rst`=0 at cycle 20 of a DIV.
  - Next cycle: `ready_o`=0, `result_o`=0, `stallreq_o`=0 with `start_i` low.
  - A DIVU issued after release completes normally in 33 cycles.
